// File: rtl/row_dma_writer.sv
// Writes one ROW_SIZE-bit row to RAM as NUM_BLOCKS words at base_addr + i*stride, with a ready handshake.
// Optional ROW_DMA_SKIP_ZERO_EN: all-zero blocks are skipped (no RAM access) instead of written.
module row_dma_writer #(
  parameter int unsigned ROW_SIZE   = 512,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [ROW_SIZE-1:0]                          row_in,
  input  logic [ADDR_W-1:0]                            base_addr,
  input  logic [ADDR_W-1:0]                            stride,
  input  logic                                         ram_ready,
  output logic                                         ram_en,
  output logic                                         ram_write,
  output logic [ADDR_W-1:0]                            ram_addr,
  output logic [BLOCK_SIZE-1:0]                        ram_data,
  output logic                                         busy,
  output logic                                         done,
  output logic [$clog2(ROW_SIZE/BLOCK_SIZE+1)-1:0]     blocks_written
);

  localparam int unsigned NUM_BLOCKS = ROW_SIZE / BLOCK_SIZE;
  localparam int unsigned IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned BW_W       = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [ROW_SIZE-1:0] row_sh;
  logic [ADDR_W-1:0]   stride_q;
  logic [ROW_SIZE-1:0] next_sh;
  logic                first_live;
  logic                next_live;
  logic                advance;

  // Latched row is consumed LSB-first; the low block of row_sh is always the word on the bus.
  assign next_sh   = row_sh >> BLOCK_SIZE;
  assign ram_data  = row_sh[BLOCK_SIZE-1:0];
  assign ram_write = ram_en;

`ifdef ROW_DMA_SKIP_ZERO_EN
  assign first_live = |row_in[BLOCK_SIZE-1:0];
  assign next_live  = |next_sh[BLOCK_SIZE-1:0];
`else
  assign first_live = 1'b1;
  assign next_live  = 1'b1;
`endif

  // A WRITE cycle with ram_en low is a skipped block and advances unconditionally.
  assign advance = !ram_en || ram_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      row_sh         <= '0;
      stride_q       <= '0;
      ram_addr       <= '0;
      ram_en         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      blocks_written <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row_sh         <= row_in;
            stride_q       <= stride;
            ram_addr       <= base_addr;
            idx            <= '0;
            blocks_written <= '0;
            ram_en         <= first_live;
            busy           <= 1'b1;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (advance) begin
            if (ram_en) begin
              blocks_written <= blocks_written + BW_W'(1);
            end
            if (idx == IDX_W'(NUM_BLOCKS - 1)) begin
              ram_en <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx      <= idx + IDX_W'(1);
              ram_addr <= ram_addr + stride_q;
              row_sh   <= next_sh;
              ram_en   <= next_live;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_dma_writer.sv
// Self-checking bench for row_dma_writer (ROW_SIZE=64, BLOCK_SIZE=16, ADDR_W=16).
// Table vectors, hand sequences for stalls/reset, and randomized rows against a transfer-list model.
module tb_row_dma_writer;

  localparam int MAXC   = 200;
  localparam int BUDGET = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] row_in;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic        ram_ready;
  logic        ram_en;
  logic        ram_write;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        busy;
  logic        done;
  logic [2:0]  blocks_written;

  row_dma_writer #(.ROW_SIZE(64), .BLOCK_SIZE(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .row_in(row_in), .base_addr(base_addr),
    .stride(stride), .ram_ready(ram_ready), .ram_en(ram_en), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .done(done),
    .blocks_written(blocks_written)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic ready_seq [0:MAXC];

  int          obs_cyc[$];
  logic [15:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_done;
  int          obs_bw;

  int          exp_cyc[$];
  logic [15:0] exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_done;
  int          exp_bw;

  typedef struct {
    logic [63:0]       row;
    logic [15:0]       base;
    logic [15:0]       strd;
    logic [3:0][15:0]  addrs;
    logic [3:0][15:0]  datas;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic ready_all(input logic v);
    for (int i = 0; i <= MAXC; i++) ready_seq[i] = v;
  endtask

  // Expected transfers: block i goes to base+i*stride; each written block waits for the next ready cycle.
  task automatic model(input logic [63:0] r, input logic [15:0] b, input logic [15:0] s);
    int t;
    logic [15:0] blk;
    logic [15:0] a;
    bit skip;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    t = 1;
    for (int i = 0; i < 4; i++) begin
      blk  = r[i*16 +: 16];
      a    = b + 16'(i) * s;
      skip = 1'b0;
`ifdef ROW_DMA_SKIP_ZERO_EN
      skip = (blk == 16'h0);
`endif
      if (skip) begin
        t++;
      end else begin
        while (!ready_seq[t] && t < MAXC) t++;
        exp_cyc.push_back(t); exp_addr.push_back(a); exp_data.push_back(blk);
        t++;
      end
    end
    exp_done = t;
    exp_bw   = exp_cyc.size();
  endtask

  task automatic run_row(input logic [63:0] r, input logic [15:0] b, input logic [15:0] s,
                         input bit poke_start);
    bit          hold_valid;
    logic [15:0] hold_addr;
    logic [15:0] hold_data;
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
    obs_done   = -1;
    obs_bw     = -1;
    hold_valid = 1'b0;
    hold_addr  = '0;
    hold_data  = '0;
    start      = 1'b1;
    row_in     = r;
    base_addr  = b;
    stride     = s;
    ram_ready  = ready_seq[0];
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      start     = poke_start && (c == 2);
      row_in    = {$urandom, $urandom};
      base_addr = 16'($urandom);
      stride    = 16'($urandom);
      ram_ready = ready_seq[c];
      check("busy_in_row", busy, 1);
      check("ram_write_eq_en", ram_write, ram_en);
      if (hold_valid) begin
        check("hold_addr", ram_addr, hold_addr);
        check("hold_data", ram_data, hold_data);
      end
      hold_valid = ram_en && !ram_ready;
      hold_addr  = ram_addr;
      hold_data  = ram_data;
      if (ram_en && ram_ready) begin
        obs_cyc.push_back(c); obs_addr.push_back(ram_addr); obs_data.push_back(ram_data);
      end
      if (done) begin
        obs_done = c;
        obs_bw   = int'(blocks_written);
        check("ram_en_in_done", ram_en, 0);
        break;
      end
    end
    if (obs_done < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("ram_en_idle", ram_en, 0);
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, obs_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      check({tag, "_cycle"}, obs_cyc[i], exp_cyc[i]);
      check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    check({tag, "_done_cycle"}, obs_done, exp_done);
    check({tag, "_blocks_written"}, obs_bw, exp_bw);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"}, ram_en, 0);
    check({tag, "_ram_write"}, ram_write, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_data"}, ram_data, 0);
    check({tag, "_blocks_written"}, blocks_written, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    logic [15:0] b;
    logic [15:0] s;

    tbl[0] = '{64'h4444_3333_2222_1111, 16'h0100, 16'h0001,
               {16'h0103, 16'h0102, 16'h0101, 16'h0100}, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[1] = '{64'h4444_3333_2222_1111, 16'hFFFE, 16'h0002,
               {16'h0004, 16'h0002, 16'h0000, 16'hFFFE}, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[2] = '{64'hDEAD_BEEF_CAFE_F00D, 16'h1234, 16'h0100,
               {16'h1534, 16'h1434, 16'h1334, 16'h1234}, {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}};
    tbl[3] = '{64'h0001_8000_FFFF_7FFF, 16'h8000, 16'hFFFF,
               {16'h7FFD, 16'h7FFE, 16'h7FFF, 16'h8000}, {16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF}};
    tbl[4] = '{64'h1234_5678_9ABC_DEF0, 16'h00AA, 16'h0000,
               {16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA}, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}};

    rst = 1'b1; start = 1'b0; ram_ready = 1'b0;
    row_in = '0; base_addr = '0; stride = '0;
    ready_all(1'b1);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Table rows, ready tied high, back-to-back; tbl[0] also pokes start mid-row.
    for (int k = 0; k < 5; k++) begin
      run_row(tbl[k].row, tbl[k].base, tbl[k].strd, k == 0);
      exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < 4; i++) begin
        exp_cyc.push_back(i + 1);
        exp_addr.push_back(tbl[k].addrs[i]);
        exp_data.push_back(tbl[k].datas[i]);
      end
      exp_done = 5;
      exp_bw   = 4;
      compare_obs($sformatf("tbl%0d", k));
    end

    // Block 1 stalled for three cycles.
    ready_all(1'b1);
    ready_seq[2] = 1'b0; ready_seq[3] = 1'b0; ready_seq[4] = 1'b0;
    run_row(64'h4444_3333_2222_1111, 16'h0100, 16'h0001, 1'b0);
    exp_cyc = '{1, 5, 6, 7};
    exp_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    exp_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_done = 8;
    exp_bw   = 4;
    compare_obs("stall");

`ifdef ROW_DMA_SKIP_ZERO_EN
    ready_all(1'b1);
    run_row(64'h0000_3333_0000_1111, 16'h0000, 16'h0001, 1'b0);
    exp_cyc = '{1, 3};
    exp_addr = '{16'h0000, 16'h0002};
    exp_data = '{16'h1111, 16'h3333};
    exp_done = 5;
    exp_bw   = 2;
    compare_obs("skip");
`endif

    // Reset on cycle 2 aborts the row.
    ready_all(1'b1);
    start = 1'b1; row_in = 64'h4444_3333_2222_1111; base_addr = 16'h0100; stride = 16'h0001;
    ram_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_reset_outputs("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_no_write", ram_en, 0);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", busy, 0);
    @(negedge clk);
    check("rst_prio_ram_en", ram_en, 0);
    check("rst_prio_busy2", busy, 0);

    run_row(tbl[1].row, tbl[1].base, tbl[1].strd, 1'b0);
    model(tbl[1].row, tbl[1].base, tbl[1].strd);
    compare_obs("post_reset");

    // Randomized rows with random ready and occasional zero blocks.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        r[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      b = 16'($urandom);
      s = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      for (int i = 0; i <= MAXC; i++) begin
        ready_seq[i] = (i > 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
      end
      model(r, b, s);
      run_row(r, b, s, $urandom_range(0, 1) == 1);
      compare_obs($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/row_dma_writer.md
ROW_DMA_WRITER -- requirements
Module: row_dma_writer

Interface
REQ-001 Parameter ROW_SIZE, default 512: width of the row to be written, in bits.
REQ-002 Parameter BLOCK_SIZE, default 16: width of one RAM word, in bits; ROW_SIZE SHALL be an integer multiple of BLOCK_SIZE, with NUM_BLOCKS = ROW_SIZE/BLOCK_SIZE.
REQ-003 Parameter ADDR_W, default 16: RAM address width.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  request to write one row; sampled only in IDLE.
REQ-007 Port row_in  input  ROW_SIZE  row data, latched on accepted start.
REQ-008 Port base_addr  input  ADDR_W  RAM address of block 0, latched on accepted start.
REQ-009 Port stride  input  ADDR_W  address increment between consecutive blocks, latched on accepted start.
REQ-010 Port ram_ready  input  1  RAM accepts the presented word this cycle.
REQ-011 Port ram_en  output  1  RAM access request.
REQ-012 Port ram_write  output  1  write strobe; equal to ram_en.
REQ-013 Port ram_addr  output  ADDR_W  write address.
REQ-014 Port ram_data  output  BLOCK_SIZE  write data.
REQ-015 Port busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-016 Port done  output  1  one-cycle pulse at the end of a row.
REQ-017 Port blocks_written  output  clog2(NUM_BLOCKS+1)  number of words actually written for the current/last row.

Function
REQ-018 States: IDLE, WRITE, DONE; registered outputs only.
REQ-019 IDLE: if start=1, latch row_in/base_addr/stride, clear block index and blocks_written, go to WRITE; otherwise stay.
REQ-020 WRITE: present block i = row bits [i*BLOCK_SIZE +: BLOCK_SIZE], block 0 being the LSBs, at ram_addr = base_addr + i*stride, truncated modulo 2^ADDR_W (wrap-around, no error).
REQ-021 WRITE handshake: ram_en=ram_write=1, with ram_addr/ram_data held stable until a cycle with ram_ready=1; in that cycle the word transfers, blocks_written increments, and i advances.
REQ-022 A transfer of block NUM_BLOCKS-1 moves the FSM to DONE; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-023 start is ignored in WRITE and DONE; a start in the cycle after DONE (IDLE) is accepted normally, giving back-to-back rows with one idle cycle between them.
REQ-024 Latency with ram_ready tied high: start accepted at cycle 0, block i written at cycle i+1, done at cycle NUM_BLOCKS+1.
REQ-025 ram_en=0 in IDLE and DONE; ram_addr/ram_data are don't-care when ram_en=0.
REQ-026 Changes on row_in/base_addr/stride during busy SHALL NOT affect the row in flight.

Reset
REQ-027 rst=1 at a clock edge forces IDLE with ram_en=ram_write=busy=done=0, ram_addr=0, ram_data=0, blocks_written=0, and block index 0.
REQ-028 rst asserted mid-row aborts the row: no further writes and no done pulse; rst takes priority over start.

Configuration
REQ-029 Macro ROW_DMA_SKIP_ZERO_EN defined: in WRITE, a block equal to all zeros is skipped in one cycle with ram_en=0 and no ram_ready dependence; i still advances (address advances by stride) and blocks_written does not increment; a skipped last block still leads to DONE.
REQ-030 Macro undefined: every block is written regardless of value, and blocks_written equals NUM_BLOCKS at done.

Verification (ROW_SIZE=64, BLOCK_SIZE=16, ADDR_W=16)
REQ-031 row_in=0x4444_3333_2222_1111, base=0x0100, stride=1, ram_ready=1 -> writes (0x0100,0x1111),(0x0101,0x2222),(0x0102,0x3333),(0x0103,0x4444) on cycles 1-4; done at cycle 5; blocks_written=4.
REQ-032 Same row with ram_ready low for 3 cycles during block 1 -> addr 0x0101/data 0x2222 held for 4 cycles; done at cycle 8.
REQ-033 base=0xFFFE, stride=2 -> addresses 0xFFFE, 0x0000, 0x0002, 0x0004.
REQ-034 start pulsed during WRITE with a different row_in -> ignored; original four words written.
REQ-035 rst asserted on cycle 2 -> ram_en=0 from the next edge, no done; all outputs at reset values.
REQ-036 With ROW_DMA_SKIP_ZERO_EN defined, row_in=0x0000_3333_0000_1111, base=0, stride=1 -> writes only (0x0000,0x1111) and (0x0002,0x3333); blocks_written=2; done at cycle 5.
